rx_timer_ctrl: RTL and testbench
================================

# rx_timer_ctrl

- Sequences a shared `flex_counter` to time one asynchronous serial frame: start bit, DATA_BITS data bits, stop bit.
- Re-programs the counter's rollover value per phase and watches its rollover flag.
- Emits per-bit sample strobes to the receive shift register, plus frame-complete, false-start and framing-error status.
- Sits between the start-bit detector and the receive datapath.

## Interface

Parameters:
- NUM_CNT_BITS, 4: counter width. B must be below 2^NUM_CNT_BITS.
- BIT_PERIOD, 10: clocks per bit, B. Legal range 4 ≤ B < 2^NUM_CNT_BITS. H = B>>1.
- DATA_BITS, 8: data bits per frame. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- start  in  1  start-edge pulse from the detector. Accepted only in IDLE.
- serial_in  in  1  synchronized serial line.
- abort  in  1  synchronous abort. Priority over all other inputs.
- cnt_rollover_flag  in  1  rollover_flag from the counter.
- cnt_clear  out  1  counter clear.
- cnt_enable  out  1  counter count_enable.
- cnt_rollover_val  out  NUM_CNT_BITS  counter rollover_val.
- bit_strobe  out  1  one-cycle pulse: sample data bit bit_index now.
- bit_index  out  4  index of the current data bit, 0..DATA_BITS-1.
- busy  out  1  high in every state except IDLE.
- false_start  out  1  one-cycle pulse: start bit not low at its midpoint.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_error  out  1  registered stop-bit error. Held until the next accepted start.

## Operation

Counter model:
- Clear is synchronous and has priority over enable.
- The counter rolls to 1 after reaching the rollover value. The flag is high while count == rollover value.
- Once cleared and enabled, the counter flags R+1 cycles after the clear cycle, then every R cycles.

Moore outputs:

| State | cnt_clear | cnt_enable | cnt_rollover_val |
|---|---|---|---|
| IDLE | 0 | 0 | B |
| CLR_HALF | 1 | 0 | H |
| HALF | 0 | 1 | H |
| CLR_BIT | 1 | 0 | B |
| BITS | 0 | 1 | B |
| STOP | 0 | 1 | B |
| DONE | 1 | 0 | B |

Transitions:
- IDLE → CLR_HALF on start. Same edge clears frame_error and bit_index.
- CLR_HALF → HALF unconditionally.
- HALF, flag=1:
  - serial_in=1: false_start=1 this cycle, next state IDLE.
  - serial_in=0: next state CLR_BIT.
- CLR_BIT → BITS. bit_index=0.
- BITS, flag=1: bit_strobe=1.
  - If bit_index == DATA_BITS-1, next state STOP.
  - Otherwise bit_index increments.
- STOP, flag=1: capture frame_error = !serial_in, next state DONE.
- DONE: frame_done=1, next state IDLE.

Rules:
- abort=1 in any state:
  - Outputs that cycle: cnt_clear=1, cnt_enable=0.
  - bit_strobe, false_start and frame_done are suppressed.
  - Next state IDLE. frame_error is unchanged.
- start is ignored outside IDLE, including in DONE.
- A held-high start retriggers only after returning to IDLE.
- cnt_rollover_flag is ignored outside HALF, BITS and STOP.
- Reset: state IDLE, bit_index=0, frame_error=0. All pulse outputs 0; busy=0, cnt_clear=0, cnt_enable=0, cnt_rollover_val=B.

## Timing

- Cycle 0 is the IDLE cycle with start=1.
  - CLR_HALF: cycle 1.
  - Start-midpoint check: cycle 2+H.
  - CLR_BIT: cycle 3+H.
- bit_strobe for bit k: cycle 4+H+B+k·B.
- Stop sample: cycle 4+H+B+DATA_BITS·B.
- frame_done: the following cycle. IDLE one cycle later.
- Defaults (B=10, H=5, DATA_BITS=8):
  - bit strobes at cycles 19, 29, …, 89;
  - stop sample at 99;
  - frame_done at 100;
  - IDLE at 101.
- All status outputs are combinational from registered state and inputs within the cycle. There is no extra output latency.
- Reset asserts asynchronously and takes effect immediately, mid-frame included. Release is synchronous to the next edge.

## Test plan

- Reset mid-frame: n_rst=0 during BITS → immediately state IDLE, busy=0, cnt_clear=0, cnt_enable=0, cnt_rollover_val=10, bit_index=0.
- Nominal frame with a real flex_counter, data 8'hA5, stop=1, start at cycle 0:
  - cnt_clear high at cycles 1, 8 and 100;
  - bit_strobe at 19…89 with bit_index 0..7;
  - frame_done at 100, frame_error=0, busy low at 101.
- False start: serial_in=1 at cycle 7 → false_start pulse at cycle 7, IDLE at 8, no bit_strobe.
- Framing error: serial_in=0 at cycle 99 → frame_done at 100 with frame_error=1. Error held through idle; cleared on the next start edge.
- Abort at cycle 50 → cycle 50 has cnt_clear=1 and cnt_enable=0; busy=0 at 51; no frame_done. Start at 52 gives a full frame with frame_done at 152.
- start held high from cycle 0 to 120 → one frame only, then a new frame starts at 101 with frame_done at 201. A start pulse during DONE (cycle 100) is ignored.

Source files
------------

// File: rtl/rx_timer_ctrl.sv
// rx_timer_ctrl: sequences a shared flex_counter through start, data and stop bits of one serial frame
//   clk, n_rst           clock and asynchronous active-low reset
//   start                start-edge pulse, accepted only when idle
//   serial_in            synchronized serial line
//   abort                synchronous abort, overrides all other inputs
//   cnt_rollover_flag    counter rollover flag
//   cnt_clear/enable     counter clear and count enable
//   cnt_rollover_val     counter rollover value for the current phase
//   bit_strobe/bit_index sample strobe and index of the current data bit
//   busy                 high whenever a frame is in progress
//   false_start          start bit not low at its midpoint
//   frame_done           frame finished
//   frame_error          stop-bit error, held until the next accepted start
module rx_timer_ctrl #(
    parameter int NUM_CNT_BITS = 4,
    parameter int BIT_PERIOD   = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    input  logic                    serial_in,
    input  logic                    abort,
    input  logic                    cnt_rollover_flag,
    output logic                    cnt_clear,
    output logic                    cnt_enable,
    output logic [NUM_CNT_BITS-1:0] cnt_rollover_val,
    output logic                    bit_strobe,
    output logic [3:0]              bit_index,
    output logic                    busy,
    output logic                    false_start,
    output logic                    frame_done,
    output logic                    frame_error
);
    localparam logic [NUM_CNT_BITS-1:0] B_VAL = NUM_CNT_BITS'(BIT_PERIOD);
    localparam logic [NUM_CNT_BITS-1:0] H_VAL = NUM_CNT_BITS'(BIT_PERIOD >> 1);
    localparam logic [3:0]              LAST  = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, CLR_HALF, HALF, CLR_BIT, BITS, STOP, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] bit_index_q, bit_index_d;
    logic       frame_error_q, frame_error_d;

    always_comb begin
        state_d          = state_q;
        bit_index_d      = bit_index_q;
        frame_error_d    = frame_error_q;
        cnt_clear        = state_q inside {CLR_HALF, CLR_BIT, DONE};
        cnt_enable       = state_q inside {HALF, BITS, STOP};
        cnt_rollover_val = (state_q == CLR_HALF || state_q == HALF) ? H_VAL : B_VAL;
        bit_strobe       = 1'b0;
        false_start      = 1'b0;
        frame_done       = 1'b0;
        if (abort) begin
            // Parking the counter in clear lets the next frame start from a known count
            cnt_clear  = 1'b1;
            cnt_enable = 1'b0;
            state_d    = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d       = CLR_HALF;
                    frame_error_d = 1'b0;
                    bit_index_d   = '0;
                end
                CLR_HALF: state_d = HALF;
                HALF: if (cnt_rollover_flag) begin
                    false_start = serial_in;
                    state_d     = serial_in ? IDLE : CLR_BIT;
                end
                CLR_BIT: begin
                    state_d     = BITS;
                    bit_index_d = '0;
                end
                BITS: if (cnt_rollover_flag) begin
                    bit_strobe  = 1'b1;
                    state_d     = (bit_index_q == LAST) ? STOP : BITS;
                    bit_index_d = (bit_index_q == LAST) ? bit_index_q : bit_index_q + 4'd1;
                end
                STOP: if (cnt_rollover_flag) begin
                    frame_error_d = !serial_in;
                    state_d       = DONE;
                end
                DONE: begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            bit_index_q   <= '0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_index_q   <= bit_index_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign busy        = state_q != IDLE;
    assign bit_index   = bit_index_q;
    assign frame_error = frame_error_q;
endmodule

// File: tb/tb_rx_timer_ctrl.sv
// tb_rx_timer_ctrl: directed scenario table and hand sequences for rx_timer_ctrl with a flex_counter model
module tb_rx_timer_ctrl;
    localparam int NB = 4;
    localparam int B  = 10;
    localparam int H  = 5;
    localparam logic [7:0] DATA = 8'hA5;

    logic          clk = 1'b0;
    logic          n_rst, start, serial_in, abort, flag;
    logic          cnt_clear, cnt_enable, bit_strobe, busy, false_start, frame_done, frame_error;
    logic [NB-1:0] cnt_rollover_val, cnt_q;
    logic [3:0]    bit_index;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    rx_timer_ctrl #(.NUM_CNT_BITS(NB), .BIT_PERIOD(B), .DATA_BITS(8)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .serial_in(serial_in), .abort(abort),
        .cnt_rollover_flag(flag), .cnt_clear(cnt_clear), .cnt_enable(cnt_enable),
        .cnt_rollover_val(cnt_rollover_val), .bit_strobe(bit_strobe), .bit_index(bit_index),
        .busy(busy), .false_start(false_start), .frame_done(frame_done), .frame_error(frame_error)
    );

    // flex_counter: clear wins, rolls to 1 after the rollover value, flag while count equals it
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) cnt_q <= '0;
        else if (cnt_clear) cnt_q <= '0;
        else if (cnt_enable) cnt_q <= (cnt_q == cnt_rollover_val) ? NB'(1) : cnt_q + 1'b1;
    end
    assign flag = cnt_q == cnt_rollover_val;

    typedef struct {
        int hold; int extra; int f1; bit fs; bit stopb; int ab; int n;
        int done_cnt; int done_first; int done_last; int strobes; int fs_cyc;
        bit err; int idle; int clr_cnt; int clr_last;
    } scen_t;

    scen_t tbl [6];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic line(input int rel, input bit stopb);
        if (rel < 14) return 1'b0;
        if (rel < 94) return DATA[(rel - 14) / 10];
        return stopb;
    endfunction

    task automatic run(input scen_t s);
        int sn = 0, base, strobes = 0, fs_cnt = 0, done_cnt = 0, done_first = -1, done_last = -1;
        int clr_cnt = 0, clr_last = -1;
        for (int c = 0; c < s.n; c++) begin
            base = (s.f1 >= 0 && c >= s.f1) ? s.f1 : 0;
            if (c == s.f1) sn = 0;
            start     = (c <= s.hold) || (c == s.extra);
            abort     = c == s.ab;
            serial_in = (s.fs && c == 7) ? 1'b1 : line(c - base, s.stopb);
            #2;
            if (bit_strobe) begin
                chk("strobe_cyc", c, base + 19 + 10 * sn);
                chk("strobe_idx", int'(bit_index), sn);
                sn++;
                strobes++;
            end
            if (false_start) begin
                fs_cnt++;
                chk("fs_cyc", c, s.fs_cyc);
            end
            if (frame_done) begin
                if (done_cnt == 0) done_first = c;
                done_last = c;
                done_cnt++;
            end
            if (cnt_clear) begin
                clr_cnt++;
                clr_last = c;
            end
            if (c == 2) begin
                chk("half_rv", int'(cnt_rollover_val), H);
                chk("half_en", int'(cnt_enable), 1);
            end
            if (c == s.ab) begin
                chk("abort_clr", int'(cnt_clear), 1);
                chk("abort_en", int'(cnt_enable), 0);
            end
            if (c == s.idle) chk("idle_busy", int'(busy), 0);
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        serial_in = 1'b1;
        #1;
        chk("done_cnt", done_cnt, s.done_cnt);
        chk("done_first", done_first, s.done_first);
        chk("done_last", done_last, s.done_last);
        chk("strobes", strobes, s.strobes);
        chk("fs_cnt", fs_cnt, s.fs_cyc >= 0 ? 1 : 0);
        chk("clr_cnt", clr_cnt, s.clr_cnt);
        chk("clr_last", clr_last, s.clr_last);
        chk("frame_error", int'(frame_error), int'(s.err));
        chk("end_busy", int'(busy), 0);
        tick();
    endtask

    initial begin
        //        hold extra f1  fs stop ab  n   dcnt dfirst dlast strb fs  err idle clr last
        tbl[0] = '{0,  -1,  -1,  0, 1,  -1, 110, 1,  100,  100,  8,   -1, 0,  101, 3,  100};
        tbl[1] = '{0,  -1,  -1,  1, 1,  -1, 20,  0,  -1,   -1,   0,   7,  0,  8,   1,  1};
        tbl[2] = '{0,  -1,  -1,  0, 0,  -1, 110, 1,  100,  100,  8,   -1, 1,  101, 3,  100};
        tbl[3] = '{0,  52,  52,  0, 1,  50, 160, 1,  152,  152,  12,  -1, 0,  51,  6,  152};
        tbl[4] = '{120,-1,  101, 0, 1,  -1, 210, 2,  100,  201,  16,  -1, 0,  101, 6,  201};
        tbl[5] = '{0,  100, -1,  0, 1,  -1, 110, 1,  100,  100,  8,   -1, 0,  101, 3,  100};
        n_rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        serial_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_clr", int'(cnt_clear), 0);
        chk("rst_en", int'(cnt_enable), 0);
        chk("rst_rv", int'(cnt_rollover_val), B);
        chk("rst_idx", int'(bit_index), 0);
        chk("rst_err", int'(frame_error), 0);
        tick();
        for (int i = 0; i < 3; i++) run(tbl[i]);
        // frame_error holds through idle and clears on the accepting edge
        #2 chk("err_held", int'(frame_error), 1);
        tick();
        start = 1'b1;
        #2 chk("err_start_cyc", int'(frame_error), 1);
        tick();
        start = 1'b0;
        #2;
        chk("err_cleared", int'(frame_error), 0);
        chk("clr_half_busy", int'(busy), 1);
        chk("clr_half_clr", int'(cnt_clear), 1);
        tick();
        abort = 1'b1;
        #2;
        chk("abort_half_clr", int'(cnt_clear), 1);
        chk("abort_half_en", int'(cnt_enable), 0);
        tick();
        abort = 1'b0;
        #2 chk("abort_half_idle", int'(busy), 0);
        tick();
        // abort beats start in IDLE
        start = 1'b1;
        abort = 1'b1;
        #2 chk("abort_idle_clr", int'(cnt_clear), 1);
        tick();
        start = 1'b0;
        abort = 1'b0;
        #2 chk("abort_idle_busy", int'(busy), 0);
        tick();
        for (int i = 3; i < 6; i++) run(tbl[i]);
        // asynchronous reset in the middle of the data bits
        start = 1'b1;
        serial_in = 1'b0;
        tick();
        start = 1'b0;
        repeat (39) tick();
        #2 chk("pre_rst_busy", int'(busy), 1);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_clr", int'(cnt_clear), 0);
        chk("mid_rst_en", int'(cnt_enable), 0);
        chk("mid_rst_rv", int'(cnt_rollover_val), B);
        chk("mid_rst_idx", int'(bit_index), 0);
        tick();
        n_rst = 1'b1;
        serial_in = 1'b1;
        tick();
        #2 chk("post_rst_busy", int'(busy), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
